riscv_trap_ctrl: RTL and testbench



---
 rtl/riscv_trap_ctrl_pkg.sv | 23 ++
 rtl/riscv_trap_ctrl_if.sv | 36 +++
 rtl/riscv_trap_ctrl.sv | 122 ++++++++++++
 tb/tb_riscv_trap_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_trap_ctrl_pkg.sv
// Shared trap encodings, CSR bit positions and FSM encodings for the trap
// sequencer and the CSR file.
package riscv_trap_ctrl_pkg;

    localparam logic [1:0] TRAP_NONE  = 2'b00;
    localparam logic [1:0] TRAP_ECALL = 2'b01;
    localparam logic [1:0] TRAP_IRQ   = 2'b10;

    localparam int MSTATUS_MIE_BIT = 3;
    localparam int MIE_MTIE_BIT    = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_JUMP   = 2'b01,
        ST_SETTLE = 2'b10
    } trap_state_e;

    typedef enum logic {
        KIND_TRAP = 1'b0,
        KIND_RET  = 1'b1
    } trap_kind_e;

endpackage

// File: rtl/riscv_trap_ctrl_if.sv
// Signal bundle between the trap sequencer and its neighbours (WB stage,
// CLINT, CSR file, IF-stage PC mux).
interface riscv_trap_ctrl_if #(
    parameter int D_BUS_WIDTH = 64
);
    logic                   i_wb_valid;
    logic                   i_wb_ecall;
    logic                   i_wb_mret;
    logic                   i_mtip;
    logic                   i_mem_busy;
    logic [D_BUS_WIDTH-1:0] i_mstatus;
    logic [D_BUS_WIDTH-1:0] i_mie;
    logic [D_BUS_WIDTH-1:0] i_mtvec;
    logic [D_BUS_WIDTH-1:0] i_mepc;
    logic [1:0]             o_excep_csr_upd;
    logic                   o_mret_csr_upd;
    logic                   o_flush;
    logic                   o_stall;
    logic                   o_redirect_valid;
    logic [D_BUS_WIDTH-1:0] o_redirect_pc;
    logic                   o_busy;

    modport slave (
        input  i_wb_valid, i_wb_ecall, i_wb_mret, i_mtip, i_mem_busy,
        input  i_mstatus, i_mie, i_mtvec, i_mepc,
        output o_excep_csr_upd, o_mret_csr_upd, o_flush, o_stall,
        output o_redirect_valid, o_redirect_pc, o_busy
    );

    modport master (
        output i_wb_valid, i_wb_ecall, i_wb_mret, i_mtip, i_mem_busy,
        output i_mstatus, i_mie, i_mtvec, i_mepc,
        input  o_excep_csr_upd, o_mret_csr_upd, o_flush, o_stall,
        input  o_redirect_valid, o_redirect_pc, o_busy
    );
endinterface

// File: rtl/riscv_trap_ctrl.sv
// Trap sequencer: takes ecall/mret/timer interrupt at mem2wb, strobes the CSR
// file, flushes the pipe and issues a one-cycle PC redirect.
module riscv_trap_ctrl
    import riscv_trap_ctrl_pkg::*;
#(
    parameter int D_BUS_WIDTH = 64,
    parameter bit MTIP_SYNC   = 1'b1
) (
    input logic               clk,
    input logic               rst,
    riscv_trap_ctrl_if.slave  bus
);

    trap_state_e state_q, state_d;
    trap_kind_e  kind_q, kind_d;
    logic        mtip_q;
    logic        mtip_s;
    logic        ev_ecall_s, ev_mret_s, irq_s;

    logic [1:0]             excep_s;
    logic                   mret_s, flush_s, stall_s, redirect_valid_s;
    logic [D_BUS_WIDTH-1:0] redirect_pc_s;
    logic                   unused_s;

    assign mtip_s = MTIP_SYNC ? mtip_q : bus.i_mtip;

    // Events are masked while reset is held so no half strobe escapes.
    assign ev_ecall_s = ~rst & bus.i_wb_valid & bus.i_wb_ecall;
    assign ev_mret_s  = ~rst & bus.i_wb_valid & bus.i_wb_mret;
    assign irq_s      = ~rst & mtip_s & bus.i_mstatus[MSTATUS_MIE_BIT]
                        & bus.i_mie[MIE_MTIE_BIT] & ~bus.i_mem_busy;

    assign unused_s = ^{bus.i_mtvec[1:0], bus.i_mepc[1:0]};

    // State, trap kind and timer synchronizer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_TRAP;
            mtip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            mtip_q  <= bus.i_mtip;
        end
    end

    // Next-state and trap-kind selection; ecall > mret > irq.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        case (state_q)
            ST_IDLE: begin
                if (ev_ecall_s) begin
                    state_d = ST_JUMP;
                    kind_d  = KIND_TRAP;
                end else if (ev_mret_s) begin
                    state_d = ST_JUMP;
                    kind_d  = KIND_RET;
                end else if (irq_s) begin
                    state_d = ST_JUMP;
                    kind_d  = KIND_TRAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_JUMP:   state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode: strobes stay combinational because mem2wb is only valid in cycle N.
    always_comb begin
        excep_s          = TRAP_NONE;
        mret_s           = 1'b0;
        flush_s          = 1'b0;
        stall_s          = 1'b0;
        redirect_valid_s = 1'b0;
        redirect_pc_s    = {D_BUS_WIDTH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (ev_ecall_s) begin
                    excep_s = TRAP_ECALL;
                    flush_s = 1'b1;
                    stall_s = 1'b1;
                end else if (ev_mret_s) begin
                    mret_s  = 1'b1;
                    flush_s = 1'b1;
                    stall_s = 1'b1;
                end else if (irq_s) begin
                    excep_s = TRAP_IRQ;
                    flush_s = 1'b1;
                    stall_s = 1'b1;
                end else begin
                    excep_s = TRAP_NONE;
                end
            end
            ST_JUMP: begin
                redirect_valid_s = 1'b1;
                flush_s          = 1'b1;
                if (kind_q == KIND_RET) begin
                    redirect_pc_s = {bus.i_mepc[D_BUS_WIDTH-1:2], 2'b00};
                end else begin
                    redirect_pc_s = {bus.i_mtvec[D_BUS_WIDTH-1:2], 2'b00};
                end
            end
            default: begin
                excep_s = TRAP_NONE;
            end
        endcase
    end

    assign bus.o_excep_csr_upd  = excep_s;
    assign bus.o_mret_csr_upd   = mret_s;
    assign bus.o_flush          = flush_s;
    assign bus.o_stall          = stall_s;
    assign bus.o_redirect_valid = redirect_valid_s;
    assign bus.o_redirect_pc    = redirect_pc_s;
    assign bus.o_busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Randomized plus directed bench for riscv_trap_ctrl against a cycle-indexed
// event model (MTIP_SYNC = 1).
module tb_riscv_trap_ctrl;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    riscv_trap_ctrl_if #(.D_BUS_WIDTH(64)) bus ();

    riscv_trap_ctrl #(.D_BUS_WIDTH(64), .MTIP_SYNC(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // model state: cycle index of the last accepted event and its kind
    int   cyc = 0;
    int   last_ev = -100;
    bit   last_ret = 1'b0;
    bit   mtip_prev = 1'b0;

    logic [1:0]  obs_excep;
    logic        obs_mret, obs_flush, obs_stall, obs_rv, obs_busy;
    logic [63:0] obs_pc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic quiet();
        bus.i_wb_valid = 1'b0;
        bus.i_wb_ecall = 1'b0;
        bus.i_wb_mret  = 1'b0;
        bus.i_mem_busy = 1'b0;
    endtask

    // One clock cycle: compare against the model mid-cycle, then advance.
    task automatic run_cycle();
        logic [1:0]  e_excep;
        logic        e_mret, e_flush, e_stall, e_rv, e_busy;
        logic [63:0] e_pc;
        bit          ec, mr, irq;
        int          since;
        @(negedge clk);
        obs_excep = bus.o_excep_csr_upd;
        obs_mret  = bus.o_mret_csr_upd;
        obs_flush = bus.o_flush;
        obs_stall = bus.o_stall;
        obs_rv    = bus.o_redirect_valid;
        obs_pc    = bus.o_redirect_pc;
        obs_busy  = bus.o_busy;
        e_excep = 2'b00; e_mret = 1'b0; e_flush = 1'b0; e_stall = 1'b0;
        e_rv = 1'b0; e_busy = 1'b0; e_pc = 64'd0;
        since = cyc - last_ev;
        if (since == 1) begin
            e_rv = 1'b1; e_flush = 1'b1; e_busy = 1'b1;
            e_pc = (last_ret ? bus.i_mepc : bus.i_mtvec) & ~64'h3;
        end else if (since == 2) begin
            e_busy = 1'b1;
        end else if (!rst) begin
            ec  = bus.i_wb_valid && bus.i_wb_ecall;
            mr  = bus.i_wb_valid && bus.i_wb_mret;
            irq = mtip_prev && bus.i_mstatus[3] && bus.i_mie[7] && !bus.i_mem_busy;
            if (ec || mr || irq) begin
                e_flush = 1'b1; e_stall = 1'b1;
                last_ev = cyc;
                last_ret = !ec && mr;
                if (ec) e_excep = 2'b01;
                else if (mr) e_mret = 1'b1;
                else e_excep = 2'b10;
            end
        end
        check_eq("excep_csr_upd",  64'(obs_excep), 64'(e_excep));
        check_eq("mret_csr_upd",   64'(obs_mret),  64'(e_mret));
        check_eq("flush",          64'(obs_flush), 64'(e_flush));
        check_eq("stall",          64'(obs_stall), 64'(e_stall));
        check_eq("redirect_valid", 64'(obs_rv),    64'(e_rv));
        check_eq("redirect_pc",    obs_pc,         e_pc);
        check_eq("busy",           64'(obs_busy),  64'(e_busy));
        if (rst) begin
            last_ev   = -100;
            mtip_prev = 1'b0;
        end else begin
            mtip_prev = bus.i_mtip;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        bus.i_mtip    = 1'b0;
        bus.i_mstatus = 64'h0;
        bus.i_mie     = 64'h0;
        bus.i_mtvec   = 64'h0;
        bus.i_mepc    = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        run_cycle();
        rst = 1'b0;
        run_cycle();
        check_eq("reset_busy", 64'(obs_busy), 64'd0);

        // ecall
        bus.i_mtvec = 64'h8000_0100;
        bus.i_wb_valid = 1'b1; bus.i_wb_ecall = 1'b1;
        run_cycle();
        check_eq("ecall_strobe", 64'(obs_excep), 64'd1);
        check_eq("ecall_flush", 64'(obs_flush), 64'd1);
        quiet();
        run_cycle();
        check_eq("ecall_redirect", obs_pc, 64'h8000_0100);
        run_cycle();
        run_cycle();
        check_eq("ecall_idle_n3", 64'(obs_busy), 64'd0);

        // mret
        bus.i_mepc = 64'h8000_0204;
        bus.i_wb_valid = 1'b1; bus.i_wb_mret = 1'b1;
        run_cycle();
        check_eq("mret_strobe", 64'(obs_mret), 64'd1);
        quiet();
        run_cycle();
        check_eq("mret_strobe_off", 64'(obs_mret), 64'd0);
        check_eq("mret_redirect", obs_pc, 64'h8000_0204);
        repeat (2) run_cycle();

        // timer interrupt, disabled then enabled
        bus.i_mie = 64'h80; bus.i_mstatus = 64'h0; bus.i_mtip = 1'b1;
        repeat (20) run_cycle();
        bus.i_mtip = 1'b0;
        run_cycle();
        bus.i_mstatus = 64'h8;
        bus.i_mtip = 1'b1;
        run_cycle();
        check_eq("irq_sync_delay", 64'(obs_excep), 64'd0);
        run_cycle();
        check_eq("irq_strobe", 64'(obs_excep), 64'd2);
        repeat (2) run_cycle();

        // simultaneous ecall + irq; pending irq taken at N+3
        bus.i_wb_valid = 1'b1; bus.i_wb_ecall = 1'b1;
        run_cycle();
        check_eq("simul_ecall_wins", 64'(obs_excep), 64'd1);
        quiet();
        repeat (2) run_cycle();
        run_cycle();
        check_eq("simul_irq_n3", 64'(obs_excep), 64'd2);
        repeat (2) run_cycle();

        // bus hold-off
        bus.i_mem_busy = 1'b1;
        repeat (5) begin
            run_cycle();
            check_eq("holdoff_none", 64'(obs_excep), 64'd0);
        end
        bus.i_mem_busy = 1'b0;
        run_cycle();
        check_eq("holdoff_release", 64'(obs_excep), 64'd2);
        bus.i_mtip = 1'b0;
        repeat (3) run_cycle();

        // ecall without valid
        bus.i_wb_ecall = 1'b1;
        run_cycle();
        check_eq("bubble_ecall", 64'(obs_flush), 64'd0);
        quiet();

        // reset in JUMP
        bus.i_wb_valid = 1'b1; bus.i_wb_ecall = 1'b1;
        run_cycle();
        quiet();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        run_cycle();
        check_eq("rst_no_redirect", 64'(obs_rv), 64'd0);
        check_eq("rst_flush", 64'(obs_flush), 64'd0);
        check_eq("rst_busy", 64'(obs_busy), 64'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.i_wb_valid = 1'($urandom_range(0, 1));
            bus.i_wb_ecall = ($urandom_range(0, 5) == 0);
            bus.i_wb_mret  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) bus.i_mtip = ~bus.i_mtip;
            bus.i_mem_busy = ($urandom_range(0, 3) == 0);
            bus.i_mstatus  = {$urandom, $urandom};
            bus.i_mie      = {$urandom, $urandom} | (($urandom_range(0, 3) != 0) ? 64'h80 : 64'h0);
            bus.i_mtvec    = {$urandom, $urandom};
            bus.i_mepc     = {$urandom, $urandom};
            rst            = ($urandom_range(0, 79) == 0);
            run_cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
